// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared definitions for the instruction fetch stage.
//   FETCH_ADDR_W / FETCH_INSTR_W : default address and instruction widths
//   opcode_t, OP_*               : opcode field values seen by fetch predecode
//   fetch_state_e                : fetch controller states
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 16;
  localparam int FETCH_INSTR_W = 16;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP = 4'd0;
  localparam opcode_t OP_BZ  = 4'd13;
  localparam opcode_t OP_JMP = 4'd14;

  // FETCH: free to issue; WAIT: request outstanding;
  // DROP: request outstanding whose data belongs to a flushed path
  typedef enum logic [1:0] {FETCH, WAIT, DROP} fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// fetch_if -- instruction memory req/ack bus.
//   req   : fetch request, held with stable addr until ack
//   addr  : word address of the request
//   ack   : completes the transaction in any cycle where req=1
//   rdata : instruction word, valid while ack=1
// Modports: master (fetch unit), slave (instruction memory).
interface fetch_if import fetch_pkg::*; #(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W
);

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo -- DEPTH-entry synchronous prefetch FIFO of {instr, pc}.
//   clock, reset_n        : clock, async active-low reset
//   push, push_instr/pc   : write an entry (caller guarantees space)
//   pop                   : remove the head (caller guarantees non-empty)
//   flush                 : empty the FIFO; wins over push and pop
//   count                 : current occupancy
//   head_instr, head_pc   : head entry, combinational from storage
module fetch_fifo import fetch_pkg::*; #(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter int DEPTH   = 2,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output logic [INSTR_W-1:0] head_instr,
  output logic [ADDR_W-1:0]  head_pc
);

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // Storage is cleared on reset so the head reads as zero out of reset;
  // DEPTH is a power of two so pointers wrap on their own.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= push_instr;
        pc_mem[wr_ptr]    <= push_pc;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage of the 16-bit 5-stage pipeline.
//   clock, reset_n         : clock, async active-low reset
//   imem (fetch_if.master) : instruction memory req/ack bus, one outstanding
//   redirect, redirect_pc  : branch/jump redirect pulse and target
//   instr_valid/ready      : handshake toward decode
//   instr, instr_pc        : prefetch FIFO head word and its address
// Optional feature: define FETCH_JUMP_PREDECODE_EN to follow jmp (opcode 14)
// targets directly from fetched words instead of continuing sequentially.
module fetch_unit import fetch_pkg::*; #(
  parameter int ADDR_W    = FETCH_ADDR_W,
  parameter int INSTR_W   = FETCH_INSTR_W,
  parameter int BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  fetch_if.master            imem,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] next_pc;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              room_after_push;

  fetch_fifo #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W),
    .DEPTH  (BUF_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_instr(imem.rdata),
    .push_pc   (addr_q),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head_instr(instr),
    .head_pc   (instr_pc)
  );

  assign imem.req    = (state_q != FETCH);
  assign imem.addr   = addr_q;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;

  // A same-cycle decode pop frees a slot, which keeps single-cycle acks
  // streaming at one word per cycle.
  assign room_after_push = (count + CNT_W'(1) - CNT_W'(pop)) < DEPTH_C;

`ifdef FETCH_JUMP_PREDECODE_EN
  logic jmp_hit;
  assign jmp_hit = (opcode_t'(imem.rdata[INSTR_W-1 -: 4]) == OP_JMP);
  assign next_pc = jmp_hit ? ADDR_W'(imem.rdata[11:0]) : addr_q + ADDR_W'(1);
`else
  assign next_pc = addr_q + ADDR_W'(1);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      addr_q  <= RESET_PC;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
    end
  end

  // pc_q is the next address to issue when no request is in flight; addr_q
  // only moves when a new request is issued, so it stays put until ack.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    push    = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          addr_d  = redirect_pc;
          state_d = WAIT;
        end else if (count < DEPTH_C) begin
          addr_d  = pc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_d = redirect_pc;
          if (imem.ack) begin
            addr_d = redirect_pc;
          end else begin
            state_d = DROP;
          end
        end else if (imem.ack) begin
          push = 1'b1;
          pc_d = next_pc;
          if (room_after_push) begin
            addr_d = next_pc;
          end else begin
            state_d = FETCH;
          end
        end
      end
      DROP: begin
        // The FIFO was flushed on entry and nothing is pushed here, so the
        // issue on ack always has space.
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (imem.ack) begin
          addr_d  = redirect ? redirect_pc : pc_q;
          state_d = WAIT;
        end
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed, scoreboarded bench for fetch_unit.
// A small memory model answers requests; every word it acks on a live path
// is queued as {instr, pc} and compared when decode takes the FIFO head.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;

  fetch_if #(.ADDR_W(16), .INSTR_W(16)) imem_bus ();

  fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .BUF_DEPTH(2),
    .RESET_PC (16'h0000)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .imem       (imem_bus),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc)
  );

  always #5 clock = ~clock;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q [$];
  bit          ack_en;
  bit          jmp_en;
  bit          drop_flag;

  // Memory contents: opcode 1 everywhere, except a jmp 0x123 at address 5
  // when jmp_en is set.
  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (jmp_en && a == 16'h0005) return 16'hE123;
    return {4'h1, a[11:0]};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge with inputs for the next rising edge set up.
  // Drives the memory response, updates the scoreboard for what the rising
  // edge will do, then advances to the next falling edge.
  task automatic tick();
    logic [31:0] head;
    imem_bus.ack   = ack_en && imem_bus.req;
    imem_bus.rdata = imem_bus.ack ? word_at(imem_bus.addr) : 16'h0000;
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check_output("sb_unexpected_word", 32'(exp_q.size()), 32'd1);
      end else begin
        head = exp_q.pop_front();
        check_output("sb_instr", instr, head[31:16]);
        check_output("sb_pc", instr_pc, head[15:0]);
      end
    end
    if (redirect) exp_q.delete();
    if (imem_bus.ack) begin
      if (!redirect && !drop_flag) exp_q.push_back({imem_bus.rdata, imem_bus.addr});
      drop_flag = 1'b0;
    end else if (redirect && imem_bus.req) begin
      drop_flag = 1'b1;
    end
    @(posedge clock);
    @(negedge clock);
    redirect     = 1'b0;
    imem_bus.ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 16'h0000;
    instr_ready    = 1'b0;
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = 16'h0000;
    ack_en         = 1'b0;
    jmp_en         = 1'b0;
    drop_flag      = 1'b0;
    @(negedge clock);
    @(negedge clock);

    // Reset state
    check_output("rst_req", imem_bus.req, 1'b0);
    check_output("rst_addr", imem_bus.addr, 16'h0000);
    check_output("rst_valid", instr_valid, 1'b0);
    check_output("rst_instr", instr, 16'h0000);
    check_output("rst_pc", instr_pc, 16'h0000);

    // First request on the first edge after release
    reset_n = 1'b1;
    tick();
    check_output("boot_req", imem_bus.req, 1'b1);
    check_output("boot_addr", imem_bus.addr, 16'h0000);

    // Streaming: ack every cycle, decode always ready
    ack_en      = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_output("seq_addr", imem_bus.addr, 32'(i));
      if (i > 0) check_output("seq_pc", instr_pc, 32'(i - 1));
      tick();
    end

    // Decode stalls: FIFO fills, requests stop, head stays put
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_output("stall_head_pc", instr_pc, 16'h0003);
      check_output("stall_head_instr", instr, word_at(16'h0003));
      if (i > 0) check_output("stall_req", imem_bus.req, 1'b0);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    tick();
    check_output("resume_req", imem_bus.req, 1'b1);
    check_output("resume_addr", imem_bus.addr, 16'h0005);
    check_output("resume_valid", instr_valid, 1'b0);

    // Redirect while a request is outstanding, ack delayed 3 cycles
    ack_en      = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    check_output("drop_valid", instr_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_output("drop_req", imem_bus.req, 1'b1);
      check_output("drop_addr_hold", imem_bus.addr, 16'h0005);
      if (i < 2) tick();
    end
    ack_en = 1'b1;
    tick();
    check_output("drop_next_addr", imem_bus.addr, 16'h0040);
    check_output("drop_no_deliver", instr_valid, 1'b0);
    tick();
    check_output("drop_first_valid", instr_valid, 1'b1);
    check_output("drop_first_pc", instr_pc, 16'h0040);

    // Redirect, ack and decode transfer all in the same cycle
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    check_output("same_cycle_addr", imem_bus.addr, 16'h0100);
    check_output("same_cycle_valid", instr_valid, 1'b0);
    tick();
    check_output("same_cycle_pc", instr_pc, 16'h0100);

    // Address wrap
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    check_output("wrap_addr_hi", imem_bus.addr, 16'hFFFF);
    tick();
    check_output("wrap_addr_lo", imem_bus.addr, 16'h0000);
    check_output("wrap_pc", instr_pc, 16'hFFFF);

    // jmp word at PC 5
    jmp_en      = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0005;
    tick();
    check_output("jmp_addr5", imem_bus.addr, 16'h0005);
    tick();
`ifdef FETCH_JUMP_PREDECODE_EN
    check_output("jmp_next_addr", imem_bus.addr, 16'h0123);
`else
    check_output("jmp_next_addr", imem_bus.addr, 16'h0006);
`endif
    check_output("jmp_instr", instr, 16'hE123);
    check_output("jmp_pc", instr_pc, 16'h0005);

    // Redirect with no request in flight issues on the next edge
    instr_ready = 1'b0;
    tick();
    check_output("idle_req", imem_bus.req, 1'b0);
    tick();
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    tick();
    check_output("idle_redir_req", imem_bus.req, 1'b1);
    check_output("idle_redir_addr", imem_bus.addr, 16'h0200);
    check_output("idle_redir_valid", instr_valid, 1'b0);
    instr_ready = 1'b1;
    tick();
    ack_en = 1'b0;
    tick();
    check_output("drain_valid", instr_valid, 1'b0);
    check_output("drain_addr", imem_bus.addr, 16'h0201);

    // Reset mid-transaction with an ack pending
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = word_at(imem_bus.addr);
    reset_n        = 1'b0;
    #1;
    check_output("midrst_req", imem_bus.req, 1'b0);
    check_output("midrst_addr", imem_bus.addr, 16'h0000);
    check_output("midrst_valid", instr_valid, 1'b0);
    @(negedge clock);
    imem_bus.ack = 1'b0;
    exp_q.delete();
    drop_flag = 1'b0;
    reset_n   = 1'b1;
    tick();
    check_output("midrst_reboot_req", imem_bus.req, 1'b1);
    check_output("midrst_reboot_addr", imem_bus.addr, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit, 5-stage pipeline; the producing end of the instruction stream the decode controller consumes. Holds the PC, fetches words from instruction memory over a req/ack handshake with one outstanding request, buffers them in a small prefetch FIFO, and presents them to decode with valid/ready. Branch/jump redirects from later stages flush the buffer and restart fetch at the new PC.

## Interface

- ADDR_W, 16: instruction address width; word-addressed.
- INSTR_W, 16: instruction width; opcode is bits [15:12].
- BUF_DEPTH, 2: prefetch FIFO entries; power of two, ≥2.
- RESET_PC, 0: first fetch address after reset.

- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held with stable imem_addr until acked.
- imem_addr  out  ADDR_W  fetch address.
- imem_ack  in  1  completes the transaction in any cycle where imem_req=1.
- imem_rdata  in  INSTR_W  instruction word; valid when imem_ack=1.
- redirect  in  1  one-cycle pulse: branch taken or jump.
- redirect_pc  in  ADDR_W  target PC; sampled when redirect=1.
- instr_valid  out  1  instr/instr_pc hold a valid entry.
- instr_ready  in  1  decode accepts; transfer when valid&ready.
- instr  out  INSTR_W  FIFO head word.
- instr_pc  out  ADDR_W  address of instr.

## Operation

- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0; FIFO empty; fetch PC=RESET_PC; state FETCH.
- States: FETCH (may issue), WAIT (request outstanding), DROP (request outstanding, its data to be discarded).
- FETCH -> WAIT: issue when FIFO count + outstanding < BUF_DEPTH; imem_req=1, imem_addr=fetch PC.
- WAIT, ack: push {imem_rdata, imem_addr} to FIFO; fetch PC += 1 (mod 2^ADDR_W, 0xFFFF wraps to 0x0000); if space remains, issue next request back-to-back, else FETCH.
- imem_req never deasserts and imem_addr never changes before ack, even on redirect.
- Redirect: FIFO flushed; fetch PC := redirect_pc. If WAIT without ack this cycle -> DROP. In DROP, ack data discarded, then issue at redirect_pc. A second redirect in DROP overwrites the latched target.
- Redirect and ack same cycle: ack data discarded; next request at redirect_pc.
- Redirect and output transfer same cycle: transfer completes (decode keeps the word); flush follows.
- FIFO full and ack impossible (issue rule guarantees space on every ack).
- Output is the FIFO head; instr/instr_pc are stable while valid and not ready.

## Timing

- Reset release: imem_req=1, imem_addr=RESET_PC on the first rising edge after reset_n rises.
- Ack at cycle N -> instr_valid=1 at N+1 (FIFO write registered, output combinational from head).
- Ack at N with space -> next imem_req with addr+1 at N+1; sustained throughput one word per cycle with single-cycle ack.
- Redirect at N -> instr_valid=0 at N+1; if no outstanding request, imem_req at redirect_pc at N+1.
- Redirect at N with request outstanding, ack at M>N -> request at redirect_pc at M+1.
- reset_n low mid-transaction: all state to reset values immediately; pending ack ignored.

## Configuration

- FETCH_JUMP_PREDECODE_EN defined: on ack of a word with opcode 14 (jmp) outside DROP, word is pushed, fetch PC := zero-extended imem_rdata[11:0], no sequential-path request is issued; controller's later redirect to the same target still flushes normally.
- Undefined: no predecode; fetch is strictly sequential until redirect.

## Structure

- Shared package fetch_pkg: opcode constants OP_NOP(0) … OP_BZ(13), OP_JMP(14); INSTR_W/ADDR_W defaults; state enum FETCH/WAIT/DROP.
- Sub-module fetch_fifo: BUF_DEPTH-entry synchronous FIFO of {instr, pc} with push, pop, flush, count, async active-low reset.

## Test plan

- Reset, ack every cycle, ready=1 -> imem_addr 0,1,2,3 on consecutive cycles; instr_pc 0,1,2 follows one cycle later.
- instr_ready=0 for 10 cycles -> exactly BUF_DEPTH words buffered, imem_req=0 after 2 acks, head word stable; release -> drains in order.
- Redirect to 0x0040 with ack delayed 3 cycles -> imem_addr holds old PC until ack, that word not delivered, next request 0x0040, first delivered instr_pc=0x0040.
- Redirect and ack same cycle, redirect_pc=0x0100 -> acked word dropped, next imem_addr=0x0100.
- Fetch from 0xFFFF -> next imem_addr=0x0000.
- With FETCH_JUMP_PREDECODE_EN, word 0xE123 at PC 5 -> next imem_addr=0x0123, PC 6 never requested; without macro -> next imem_addr=6.
